// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: a one-hot T1..T6 ring plus an opcode decoder that
// drives the active-low load/enable pins of the datapath registers.
module sap1_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [3:0] opcode,
   output logic       pc_inc,
   output logic       pc_en_n,
   output logic       mar_load_n,
   output logic       ram_en_n,
   output logic       ir_load_n,
   output logic       ir_en_n,
   output logic       a_load_n,
   output logic       a_en_n,
   output logic       b_load_n,
   output logic       alu_en_n,
   output logic       alu_sub,
   output logic       out_load_n,
   output logic       halted,
   output logic [5:0] t_state
);

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } t_state_e;

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   t_state_e state_q, state_d;
   logic     halted_q, halted_d;

   // run is a plain advance qualifier: the ring steps on every edge where
   // run=1 and nothing is halted; there is no handshake back to the source.
   always_comb begin
      state_d  = state_q;
      halted_d = halted_q;
      if (rst) begin
         state_d  = T1;
         halted_d = 1'b0;
      end else if (!halted_q && run) begin
         case (state_q)
            T1:      state_d = T2;
            T2:      state_d = T3;
            T3:      state_d = T4;
            T4:      state_d = T5;
            T5:      state_d = T6;
            T6:      state_d = T1;
            default: state_d = T1;
         endcase
         if (state_q == T4 && opcode == OP_HLT) halted_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      state_q  <= state_d;
      halted_q <= halted_d;
   end

   assign t_state = state_q;
   assign halted  = halted_q;

   // Reset and halt both force the inactive word so no pulse leaks out.
   always_comb begin
      pc_inc     = 1'b0;
      pc_en_n    = 1'b1;
      mar_load_n = 1'b1;
      ram_en_n   = 1'b1;
      ir_load_n  = 1'b1;
      ir_en_n    = 1'b1;
      a_load_n   = 1'b1;
      a_en_n     = 1'b1;
      b_load_n   = 1'b1;
      alu_en_n   = 1'b1;
      alu_sub    = 1'b0;
      out_load_n = 1'b1;
      if (!rst && !halted_q) begin
         case (state_q)
            T1: begin
               pc_en_n    = 1'b0;
               mar_load_n = 1'b0;
            end
            T2: pc_inc = 1'b1;
            T3: begin
               ram_en_n  = 1'b0;
               ir_load_n = 1'b0;
            end
            T4: begin
               if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                  ir_en_n    = 1'b0;
                  mar_load_n = 1'b0;
               end else if (opcode == OP_OUT) begin
                  a_en_n     = 1'b0;
                  out_load_n = 1'b0;
               end
            end
            T5: begin
               if (opcode == OP_LDA) begin
                  ram_en_n = 1'b0;
                  a_load_n = 1'b0;
               end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                  ram_en_n = 1'b0;
                  b_load_n = 1'b0;
                  alu_sub  = (opcode == OP_SUB);
               end
            end
            T6: begin
               if (opcode == OP_ADD || opcode == OP_SUB) begin
                  alu_en_n = 1'b0;
                  a_load_n = 1'b0;
                  alu_sub  = (opcode == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

   bus_exclusive_a: assert property (@(posedge clk)
      $onehot0({~pc_en_n, ~ram_en_n, ~ir_en_n, ~a_en_n, ~alu_en_n}));

endmodule

// File: tb/tb_sap1_controller.sv
// Randomized bench for sap1_controller: a driver pushes the expected word for
// each cycle into a queue; a negedge monitor pops and compares.
module tb_sap1_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b1;
   logic [3:0] opcode = 4'h0;
   logic       pc_inc, pc_en_n, mar_load_n, ram_en_n, ir_load_n, ir_en_n;
   logic       a_load_n, a_en_n, b_load_n, alu_en_n, alu_sub, out_load_n;
   logic       halted;
   logic [5:0] t_state;

   sap1_controller dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode),
      .pc_inc(pc_inc), .pc_en_n(pc_en_n), .mar_load_n(mar_load_n),
      .ram_en_n(ram_en_n), .ir_load_n(ir_load_n), .ir_en_n(ir_en_n),
      .a_load_n(a_load_n), .a_en_n(a_en_n), .b_load_n(b_load_n),
      .alu_en_n(alu_en_n), .alu_sub(alu_sub), .out_load_n(out_load_n),
      .halted(halted), .t_state(t_state)
   );

   always #5 clk = ~clk;

   // Word bit positions: {control[11:0], halted, t_state[5:0]}
   localparam int P_PC_INC = 11, P_PC_EN = 10, P_MAR_LD = 9, P_RAM_EN = 8;
   localparam int P_IR_LD = 7, P_IR_EN = 6, P_A_LD = 5, P_A_EN = 4;
   localparam int P_B_LD = 3, P_ALU_EN = 2, P_ALU_SUB = 1, P_OUT_LD = 0;
   localparam logic [11:0] CW_IDLE = 12'h7FD;

   logic [18:0] exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int          ms = 1;          // model T-state number, 1..6
   logic        mh = 1'b0;       // model halted flag

   // Expected control word written as the instruction table: which pins are
   // asserted for each (T-state, instruction) pair.
   function automatic logic [11:0] model_cw(input int t, input logic h,
                                            input logic r, input logic [3:0] op);
      logic [11:0] cw;
      cw = CW_IDLE;
      if (r || h) return cw;
      if (t == 1) begin cw[P_PC_EN] = 1'b0; cw[P_MAR_LD] = 1'b0; end
      if (t == 2) cw[P_PC_INC] = 1'b1;
      if (t == 3) begin cw[P_RAM_EN] = 1'b0; cw[P_IR_LD] = 1'b0; end
      case (op)
         4'h0: begin
            if (t == 4) begin cw[P_IR_EN] = 1'b0; cw[P_MAR_LD] = 1'b0; end
            if (t == 5) begin cw[P_RAM_EN] = 1'b0; cw[P_A_LD] = 1'b0; end
         end
         4'h1, 4'h2: begin
            if (t == 4) begin cw[P_IR_EN] = 1'b0; cw[P_MAR_LD] = 1'b0; end
            if (t == 5) begin cw[P_RAM_EN] = 1'b0; cw[P_B_LD] = 1'b0; end
            if (t == 6) begin cw[P_ALU_EN] = 1'b0; cw[P_A_LD] = 1'b0; end
            if ((t == 5 || t == 6) && op == 4'h2) cw[P_ALU_SUB] = 1'b1;
         end
         4'hE: if (t == 4) begin cw[P_A_EN] = 1'b0; cw[P_OUT_LD] = 1'b0; end
         default: ;
      endcase
      return cw;
   endfunction

   // One cycle: advance the model across the edge using the inputs that were
   // live at it, then apply new inputs and queue the word expected this cycle.
   task automatic step(input logic r, input logic rn, input logic [3:0] op);
      logic [5:0] ts;
      @(posedge clk);
      if (rst) begin
         ms = 1;
         mh = 1'b0;
      end else if (!mh && run) begin
         if (ms == 4 && opcode == 4'hF) mh = 1'b1;
         ms = (ms == 6) ? 1 : ms + 1;
      end
      #1;
      rst = r;
      run = rn;
      opcode = op;
      ts = 6'b000001 << (ms - 1);
      exp_q.push_back({model_cw(ms, mh, r, op), mh, ts});
   endtask

   task automatic run_instr(input logic [3:0] op);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, op);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, 4'($urandom_range(0, 15)));
   endtask

   always @(negedge clk) begin
      logic [18:0] exp_w, got_w;
      if (exp_q.size() > 0) begin
         exp_w = exp_q.pop_front();
         got_w = {pc_inc, pc_en_n, mar_load_n, ram_en_n, ir_load_n, ir_en_n,
                  a_load_n, a_en_n, b_load_n, alu_en_n, alu_sub, out_load_n,
                  halted, t_state};
         checks++;
         if (got_w !== exp_w) begin
            errors++;
            $display("FAIL word @%0t: got cw=%b halted=%b t=%b, expected cw=%b halted=%b t=%b",
                     $time, got_w[18:7], got_w[6], got_w[5:0],
                     exp_w[18:7], exp_w[6], exp_w[5:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      do_reset(3);
      run_instr(4'h0);
      run_instr(4'h1);
      run_instr(4'h2);
      run_instr(4'hE);
      run_instr(4'h5);
      // Single-step: hold in T2 for several cycles, then resume
      step(1'b0, 1'b1, 4'h0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'h0);
      // Mid-instruction reset landing in T5 of an ADD
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'h1);
      step(1'b1, 1'b1, 4'h1);
      step(1'b0, 1'b1, 4'h1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'h1);
      // Halt, stay frozen with random run, then recover by reset
      run_instr(4'hF);
      for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom_range(0, 1)), 4'hF);
      do_reset(2);
      for (int op = 0; op < 15; op++) run_instr(4'(op));
      run_instr(4'hF);
      step(1'b0, 1'b1, 4'h0);
      do_reset(1);
      // Random traffic; opcode only changes at instruction boundaries
      begin
         logic [3:0] cur_op;
         cur_op = 4'($urandom_range(0, 15));
         for (int i = 0; i < 400; i++) begin
            if (ms == 6 || mh) cur_op = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 39) == 0) || (mh && $urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 3) != 0), cur_op);
         end
      end
      step(1'b0, 1'b1, 4'h0);
      repeat (2) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d words left unchecked, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
